// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button input and conditioned event outputs
// The slave modport is the conditioner; the master modport is whoever drives the button.
interface button_conditioner_if;
    logic       btn_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       btn_level;
    logic [1:0] state_dbg;

    modport master (
        output btn_in,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  btn_level,
        input  state_dbg
    );

    modport slave (
        input  btn_in,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse,
        output btn_level,
        output state_dbg
    );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and pulse-encode one push-button
// Emits press/release pulses plus long-press and auto-repeat pulses while held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_PRESS      = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    button_conditioner_if.slave bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS);
    localparam int RPT_W  = $clog2(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);
    localparam logic [RPT_W-1:0]  RPT_ONE   = RPT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    logic              r_s1;
    logic              r_s2;
    state_t            r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [RPT_W-1:0]  r_rpt_cnt;
    logic              r_long_done;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_repeat;
    logic              r_level;

    state_t            w_state;
    logic [DB_W-1:0]   w_db_cnt;
    logic [HOLD_W-1:0] w_hold_cnt;
    logic [RPT_W-1:0]  w_rpt_cnt;
    logic              w_long_done;
    logic              w_press;
    logic              w_release;
    logic              w_long;
    logic              w_repeat;
    logic              w_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.btn_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_rpt_cnt   <= '0;
            r_long_done <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_repeat    <= 1'b0;
            r_level     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_db_cnt    <= w_db_cnt;
            r_hold_cnt  <= w_hold_cnt;
            r_rpt_cnt   <= w_rpt_cnt;
            r_long_done <= w_long_done;
            r_press     <= w_press;
            r_release   <= w_release;
            r_long      <= w_long;
            r_repeat    <= w_repeat;
            r_level     <= w_level;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_db_cnt    = r_db_cnt;
        w_hold_cnt  = r_hold_cnt;
        w_rpt_cnt   = r_rpt_cnt;
        w_long_done = r_long_done;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_level     = r_level;

        unique case (r_state)
            ST_IDLE: begin
                if (r_s2) begin
                    w_state  = ST_PRESS_DB;
                    w_db_cnt = '0;
                end
            end

            ST_PRESS_DB: begin
                if (!r_s2) begin
                    w_state  = ST_IDLE;
                    w_db_cnt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state     = ST_HELD;
                    w_db_cnt    = '0;
                    w_press     = 1'b1;
                    w_level     = 1'b1;
                    w_hold_cnt  = '0;
                    w_rpt_cnt   = '0;
                    w_long_done = 1'b0;
                end else begin
                    w_db_cnt = r_db_cnt + DB_ONE;
                end
            end

            ST_HELD: begin
                // A falling btn_s takes priority over any long/repeat expiry this edge.
                if (!r_s2) begin
                    w_state  = ST_RELEASE_DB;
                    w_db_cnt = '0;
                end else if (!r_long_done) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_long      = 1'b1;
                        w_long_done = 1'b1;
                        w_rpt_cnt   = '0;
                    end else begin
                        w_hold_cnt = r_hold_cnt + HOLD_ONE;
                    end
                end else begin
                    if (r_rpt_cnt == RPT_LAST) begin
                        w_repeat  = 1'b1;
                        w_rpt_cnt = '0;
                    end else begin
                        w_rpt_cnt = r_rpt_cnt + RPT_ONE;
                    end
                end
            end

            ST_RELEASE_DB: begin
                // Hold and repeat counters stay frozen so a glitch only delays them.
                if (r_s2) begin
                    w_state  = ST_HELD;
                    w_db_cnt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state   = ST_IDLE;
                    w_db_cnt  = '0;
                    w_release = 1'b1;
                    w_level   = 1'b0;
                end else begin
                    w_db_cnt = r_db_cnt + DB_ONE;
                end
            end

            default: begin
                w_state  = ST_IDLE;
                w_db_cnt = '0;
            end
        endcase
    end

    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.long_pulse    = r_long;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.btn_level     = r_level;
    assign bus.state_dbg     = r_state;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench with run-length model of the conditioner
module tb_button_conditioner;
    localparam int D = 4;
    localparam int L = 10;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if u_if ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_PRESS     (L),
        .REPEAT_CYCLES  (R)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: debounced level flips on the (D+1)th consecutive disagreeing btn_s sample;
    // t counts held edges spent in steady hold, long at t==L, repeats at t==L+n*R.
    int m_s1, m_s2, m_lvl, m_run, m_t;
    int exp_press, exp_rel, exp_long, exp_rpt, exp_state;

    int n_press, n_rel, n_long, n_rpt;
    int e_press, e_rel, e_long, e_rpt1;
    int saw_rd;
    int k, rr;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_step(input int b, input int r);
        int bs;
        exp_press = 0; exp_rel = 0; exp_long = 0; exp_rpt = 0;
        if (r != 0) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_t = 0;
        end else begin
            bs   = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            if (bs != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = 1 - m_lvl;
                    m_run = 0;
                    if (m_lvl == 1) begin
                        exp_press = 1;
                        m_t = 0;
                    end else begin
                        exp_rel = 1;
                    end
                end
            end else begin
                if (m_lvl == 1 && m_run == 0) begin
                    m_t++;
                    if (m_t == L) exp_long = 1;
                    else if (m_t > L && (m_t - L) % R == 0) exp_rpt = 1;
                end
                m_run = 0;
            end
        end
        if (m_lvl == 0) exp_state = (m_run == 0) ? 0 : 1;
        else            exp_state = (m_run == 0) ? 2 : 3;
    endtask

    task automatic clear_rec();
        n_press = 0; n_rel = 0; n_long = 0; n_rpt = 0;
        e_press = -1; e_rel = -1; e_long = -1; e_rpt1 = -1;
        saw_rd = 0;
    endtask

    task automatic step(input logic b, input logic r);
        u_if.btn_in = b;
        rst = r;
        @(posedge clk);
        cyc++;
        model_step(int'(b), int'(r));
        #1;
        check("press_pulse",   int'(u_if.press_pulse),   exp_press);
        check("release_pulse", int'(u_if.release_pulse), exp_rel);
        check("long_pulse",    int'(u_if.long_pulse),    exp_long);
        check("repeat_pulse",  int'(u_if.repeat_pulse),  exp_rpt);
        check("btn_level",     int'(u_if.btn_level),     m_lvl);
        check("state_dbg",     int'(u_if.state_dbg),     exp_state);
        if (u_if.press_pulse)   begin n_press++; e_press = cyc; end
        if (u_if.release_pulse) begin n_rel++;   e_rel   = cyc; end
        if (u_if.long_pulse)    begin n_long++;  e_long  = cyc; end
        if (u_if.repeat_pulse) begin
            if (n_rpt == 0) e_rpt1 = cyc;
            n_rpt++;
        end
        if (u_if.state_dbg == 2'd3) saw_rd = 1;
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        u_if.btn_in = 1'b0;
        clear_rec();

        // 1: reset with the button pressed
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("rst_level", int'(u_if.btn_level), 0);
        check("rst_state", int'(u_if.state_dbg), 0);
        check("rst_press", int'(u_if.press_pulse), 0);

        // 2: clean press from edge 5 for 12 cycles
        run(1'b0, 2);
        clear_rec();
        run(1'b1, 12);
        run(1'b0, 10);
        check("clean_press_edge", e_press, 11);
        check("clean_release_edge", e_rel, 23);
        check("clean_press_count", n_press, 1);
        check("clean_long_count", n_long, 0);

        // 3: bounce never reaches the debounce length
        clear_rec();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        run(1'b0, 8);
        check("bounce_pulses", n_press + n_rel + n_long + n_rpt, 0);
        check("bounce_level", int'(u_if.btn_level), 0);
        check("bounce_state", int'(u_if.state_dbg), 0);

        // 4: long hold with auto-repeat
        clear_rec();
        k = cyc + 1;
        run(1'b1, 40);
        run(1'b0, 10);
        check("long_press_edge", e_press, k + 6);
        check("long_edge", e_long, k + 16);
        check("long_first_repeat", e_rpt1, k + 19);
        check("long_repeat_count", n_rpt, 8);
        check("long_release_edge", e_rel, k + 46);

        // 5: two-cycle release glitch while held
        clear_rec();
        k = cyc + 1;
        run(1'b1, 9);
        run(1'b0, 2);
        run(1'b1, 15);
        run(1'b0, 10);
        check("glitch_saw_rd", saw_rd, 1);
        check("glitch_long_edge", e_long, k + 19);
        check("glitch_repeat_count", n_rpt, 2);
        check("glitch_release_count", n_rel, 1);
        check("glitch_release_edge", e_rel, k + 32);

        // 7: btn_s falls on the very edge the long count would expire
        clear_rec();
        k = cyc + 1;
        run(1'b1, 14);
        run(1'b0, 10);
        check("race_long_count", n_long, 0);
        check("race_release_edge", e_rel, k + 20);

        // 6: reset mid-hold, button still pressed afterwards
        clear_rec();
        run(1'b1, 10);
        step(1'b1, 1'b1);
        rr = cyc;
        check("midrst_level", int'(u_if.btn_level), 0);
        check("midrst_state", int'(u_if.state_dbg), 0);
        clear_rec();
        run(1'b1, 12);
        run(1'b0, 10);
        check("midrst_press_edge", e_press, rr + 7);
        check("midrst_press_count", n_press, 1);
        check("midrst_long_count", n_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
